// File: rtl/bootrom_ahb_pkg.sv
// bootrom_ahb_pkg: FSM states, HTRANS codes and ROM timing shared by the boot ROM reader.
package bootrom_ahb_pkg;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MISS_WAIT,
      ST_DATA_ROM,
      ST_DATA_BUF,
      ST_ERR1,
      ST_ERR2
   } state_t;
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;
   localparam int ROM_LATENCY = 1;
endpackage

// File: rtl/bootrom_prefetch_buf.sv
// bootrom_prefetch_buf: one-entry next-word buffer with in-flight prefetch tag and hit compare.
module bootrom_prefetch_buf
   import bootrom_ahb_pkg::*;
#(
   parameter int AW = 8
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic [AW-1:0] i_lookup_addr,
   input  logic          i_pf_issue,
   input  logic [AW-1:0] i_pf_addr,
   input  logic          i_consume,
   input  logic          i_take,
   input  logic [31:0]   i_rom_rdata,
   output logic          o_buf_hit,
   output logic          o_fl_hit,
   output logic [31:0]   o_data
);
   logic          r_vld;
   logic [AW-1:0] r_addr;
   logic [31:0]   r_data;
   logic          r_fl_vld;
   logic [AW-1:0] r_fl_addr;
   logic          r_ret_vld;
   logic [AW-1:0] r_ret_addr;
   logic [31:0]   r_out;
   assign o_buf_hit = r_vld && r_addr == i_lookup_addr;
   assign o_fl_hit  = r_fl_vld && r_fl_addr == i_lookup_addr;
   assign o_data    = r_out;
   // r_out freezes the hit word so a same-edge refill cannot corrupt the data phase
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_vld      <= 1'b0;
         r_addr     <= '0;
         r_data     <= '0;
         r_fl_vld   <= 1'b0;
         r_fl_addr  <= '0;
         r_ret_vld  <= 1'b0;
         r_ret_addr <= '0;
         r_out      <= '0;
      end else begin
         r_fl_vld   <= i_pf_issue;
         r_fl_addr  <= i_pf_addr;
         r_ret_vld  <= r_fl_vld;
         r_ret_addr <= r_fl_addr;
         if (r_ret_vld && !i_consume) begin
            r_vld  <= 1'b1;
            r_addr <= r_ret_addr;
            r_data <= i_rom_rdata;
         end
         if (i_take) r_out <= r_data;
      end
   end
endmodule

// File: rtl/bootrom_ahb_reader.sv
// bootrom_ahb_reader: AHB-Lite read-only slave driving a registered synchronous boot ROM port.
module bootrom_ahb_reader
   import bootrom_ahb_pkg::*;
#(
   parameter int AW_ADDR_W = 8,
   parameter bit PREFETCH  = 1'b1
) (
   input  logic                 HCLK,
   input  logic                 HRESETn,
   input  logic                 HSEL,
   input  logic [31:0]          HADDR,
   input  logic [1:0]           HTRANS,
   input  logic                 HWRITE,
   input  logic [2:0]           HSIZE,
   input  logic                 HREADY,
   output logic                 HREADYOUT,
   output logic                 HRESP,
   output logic [31:0]          HRDATA,
   output logic                 ROM_EN,
   output logic [AW_ADDR_W-1:0] ROM_W_ADDR,
   input  logic [31:0]          ROM_RDATA
);
   state_t                 r_state, w_nxt;
   logic                   r_rom_en, r_rom_dem;
   logic [AW_ADDR_W-1:0]   r_rom_addr;
   logic [AW_ADDR_W-1:0]   w_addr, w_pf_addr;
   logic                   w_accept, w_rd, w_buf_hit, w_fl_hit, w_hit, w_miss, w_pf_issue;
   logic [31:0]            w_buf_data;
   logic                   w_unused;
   assign w_addr     = HADDR[AW_ADDR_W+1:2];
   assign w_accept   = HSEL & HTRANS[1] & HREADY & HREADYOUT;
   assign w_rd       = w_accept & ~HWRITE;
   assign w_hit      = w_buf_hit | w_fl_hit;
   assign w_miss     = w_rd & ~w_hit;
   // next word follows a demand that just used the port, or a hit accepted at this edge
   assign w_pf_issue = PREFETCH && !w_miss && ((r_rom_en && r_rom_dem) || (w_rd && w_hit));
   assign w_pf_addr  = (w_rd && w_hit) ? w_addr + 1'b1 : r_rom_addr + 1'b1;
   assign ROM_EN     = r_rom_en;
   assign ROM_W_ADDR = r_rom_addr;
   assign w_unused   = ^{HSIZE, HADDR[31:AW_ADDR_W+2], HADDR[1:0], HTRANS[0]};
   generate
      if (PREFETCH) begin : g_pf
         bootrom_prefetch_buf #(.AW(AW_ADDR_W)) u_buf (
            .i_clk         (HCLK),
            .i_rst_n       (HRESETn),
            .i_lookup_addr (w_addr),
            .i_pf_issue    (w_pf_issue),
            .i_pf_addr     (w_pf_addr),
            .i_consume     (r_state == ST_DATA_ROM),
            .i_take        (w_rd & w_buf_hit),
            .i_rom_rdata   (ROM_RDATA),
            .o_buf_hit     (w_buf_hit),
            .o_fl_hit      (w_fl_hit),
            .o_data        (w_buf_data)
         );
      end else begin : g_nopf
         assign w_buf_hit  = 1'b0;
         assign w_fl_hit   = 1'b0;
         assign w_buf_data = '0;
      end
   endgenerate
   always_ff @(posedge HCLK) begin
      if (!HRESETn) r_state <= ST_IDLE;
      else r_state <= w_nxt;
   end
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         r_rom_en   <= 1'b0;
         r_rom_dem  <= 1'b0;
         r_rom_addr <= '0;
      end else begin
         r_rom_en   <= w_miss | w_pf_issue;
         r_rom_dem  <= w_miss;
         r_rom_addr <= w_miss ? w_addr : w_pf_issue ? w_pf_addr : r_rom_addr;
      end
   end
   always_comb begin
      w_nxt = r_state == ST_MISS_WAIT ? ST_DATA_ROM :
              r_state == ST_ERR1      ? ST_ERR2 :
              !w_accept               ? ST_IDLE :
              HWRITE                  ? ST_ERR1 :
              w_buf_hit               ? ST_DATA_BUF :
              w_fl_hit                ? ST_DATA_ROM : ST_MISS_WAIT;
   end
   always_comb begin
      HREADYOUT = !(r_state == ST_MISS_WAIT || r_state == ST_ERR1);
      HRESP     = r_state == ST_ERR1 || r_state == ST_ERR2;
      HRDATA    = r_state == ST_DATA_ROM ? ROM_RDATA :
                  r_state == ST_DATA_BUF ? w_buf_data : '0;
   end
endmodule
